// File: rtl/pipe_control_unit_pkg.sv
// Shared constants and control-bundle types for the pipelined control unit.
package pipe_control_unit_pkg;

   localparam int OPC_BITS   = 5;
   localparam int ALUOP_BITS = 2;
   localparam int RFSEL_BITS = 2;

   // RV32I major opcodes, instruction bits [6:2]
   localparam logic [OPC_BITS-1:0] OPC_LOAD    = 5'b00000;
   localparam logic [OPC_BITS-1:0] OPC_FENCE   = 5'b00011;
   localparam logic [OPC_BITS-1:0] OPC_ARITH_I = 5'b00100;
   localparam logic [OPC_BITS-1:0] OPC_AUIPC   = 5'b00101;
   localparam logic [OPC_BITS-1:0] OPC_STORE   = 5'b01000;
   localparam logic [OPC_BITS-1:0] OPC_ARITH_R = 5'b01100;
   localparam logic [OPC_BITS-1:0] OPC_LUI     = 5'b01101;
   localparam logic [OPC_BITS-1:0] OPC_BRANCH  = 5'b11000;
   localparam logic [OPC_BITS-1:0] OPC_JALR    = 5'b11001;
   localparam logic [OPC_BITS-1:0] OPC_JAL     = 5'b11011;
   localparam logic [OPC_BITS-1:0] OPC_SYSTEM  = 5'b11100;

   localparam logic [ALUOP_BITS-1:0] ALUOP_ADD   = 2'd0;
   localparam logic [ALUOP_BITS-1:0] ALUOP_SUB   = 2'd1;
   localparam logic [ALUOP_BITS-1:0] ALUOP_FUNC  = 2'd2;
   localparam logic [ALUOP_BITS-1:0] ALUOP_UPPER = 2'd3;  // LUI/AUIPC and unknown opcodes

   // Register-file write-data source
   localparam logic [RFSEL_BITS-1:0] RFSEL_ALU   = 2'd0;
   localparam logic [RFSEL_BITS-1:0] RFSEL_IMM   = 2'd1;
   localparam logic [RFSEL_BITS-1:0] RFSEL_AUIPC = 2'd2;
   localparam logic [RFSEL_BITS-1:0] RFSEL_PC4   = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [ALUOP_BITS-1:0] alu_op;
      logic                  alu_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } mem_ctrl_t;

   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [RFSEL_BITS-1:0] rf_sel;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Each stage keeps only the groups still ahead of it
   typedef struct packed {
      logic      valid;
      logic      is_ebreak;
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } idex_t;

   typedef struct packed {
      logic      valid;
      logic      is_ebreak;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } exmem_t;

   typedef struct packed {
      logic     valid;
      logic     is_ebreak;
      wb_ctrl_t wb;
   } memwb_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle table, plus EBREAK and FENCE flags.
module ctrl_decode
   import pipe_control_unit_pkg::*;
(
   input  logic [OPC_BITS-1:0] opcode,
   input  logic                inst20,
   output logic [CTRL_W-1:0]   ctrl,
   output logic                is_ebreak,
   output logic                is_fence
);

   ctrl_t c;

   // Table lookup; unknown opcodes fall through to the defaults below
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      c           = '0;
      c.ex.alu_op = ALUOP_UPPER;
      c.wb.rf_sel = RFSEL_ALU;
      is_ebreak   = 1'b0;
      is_fence    = 1'b0;
      unique case (opcode)
         OPC_JALR: begin
            c.ex.alu_op = ALUOP_ADD; c.mem.branch = 1'b1; c.ex.alu_src = 1'b1;
            c.wb.reg_write = 1'b1;   c.wb.rf_sel = RFSEL_PC4;
         end
         OPC_BRANCH: begin
            c.ex.alu_op = ALUOP_SUB; c.mem.branch = 1'b1;
         end
         OPC_LOAD: begin
            c.ex.alu_op = ALUOP_ADD; c.mem.mem_read = 1'b1; c.wb.mem_to_reg = 1'b1;
            c.ex.alu_src = 1'b1;     c.wb.reg_write = 1'b1;
         end
         OPC_STORE: begin
            c.ex.alu_op = ALUOP_ADD; c.mem.mem_write = 1'b1; c.ex.alu_src = 1'b1;
         end
         OPC_ARITH_I: begin
            c.ex.alu_op = ALUOP_FUNC; c.ex.alu_src = 1'b1; c.wb.reg_write = 1'b1;
         end
         OPC_ARITH_R: begin
            c.ex.alu_op = ALUOP_FUNC; c.wb.reg_write = 1'b1;
         end
         OPC_JAL: begin
            c.ex.alu_op = ALUOP_ADD; c.mem.branch = 1'b1; c.wb.reg_write = 1'b1;
            c.wb.rf_sel = RFSEL_PC4;
         end
         OPC_AUIPC: begin
            c.ex.alu_op = ALUOP_UPPER; c.wb.reg_write = 1'b1; c.wb.rf_sel = RFSEL_AUIPC;
         end
         OPC_LUI: begin
            c.ex.alu_op = ALUOP_UPPER; c.wb.reg_write = 1'b1; c.wb.rf_sel = RFSEL_IMM;
         end
         OPC_SYSTEM: begin
            // ECALL and EBREAK share the bundle; only bit 20 tells them apart
            c.ex.alu_op = ALUOP_FUNC; c.ex.alu_src = 1'b1;
            is_ebreak   = inst20;
         end
         OPC_FENCE: begin
            c.ex.alu_op = ALUOP_ADD;
            is_fence    = 1'b1;
         end
         default: ;
      endcase
   end

   assign ctrl = c;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// bubble insertion for stall/flush/FENCE drain, and the EBREAK halt FSM.
module pipe_control_unit
   import pipe_control_unit_pkg::*;
#(
   parameter int OPC_W          = OPC_BITS,
   parameter int ALUOP_W        = ALUOP_BITS,
   parameter int RFSEL_W        = RFSEL_BITS,
   parameter bit FENCE_DRAIN    = 1'b1,
   parameter bit HALT_ON_EBREAK = 1'b1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [OPC_W-1:0]   id_opcode,
   input  logic               id_inst20,
   input  logic               stall,
   input  logic               flush,
   input  logic               resume,
   output logic               pc_write,
   output logic               ifid_write,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic               ex_ALUSrc,
   output logic               mem_Branch,
   output logic               mem_MemRead,
   output logic               mem_MemWrite,
   output logic               wb_MemtoReg,
   output logic               wb_RegWrite,
   output logic [RFSEL_W-1:0] wb_rfWriteSelect,
   output logic               idex_valid,
   output logic               exmem_valid,
   output logic               memwb_valid,
   output logic               fence_busy,
   output logic               halted
);

   logic [CTRL_W-1:0] dec_bits;
   ctrl_t             dec;
   logic              dec_ebreak;
   logic              dec_fence;

   ctrl_decode u_decode (
      .opcode    (id_opcode),
      .inst20    (id_inst20),
      .ctrl      (dec_bits),
      .is_ebreak (dec_ebreak),
      .is_fence  (dec_fence)
   );

   assign dec = dec_bits;

   state_t state;
   idex_t  idex;
   exmem_t exmem;
   memwb_t memwb;

   logic store_in_flight;
   logic fence_hold;
   logic inject;
   logic ebreak_enter;
   logic ebreak_killed;
   logic ebreak_retired;
   logic advance;

   assign store_in_flight = (idex.valid & idex.mem.mem_write) | (exmem.valid & exmem.mem.mem_write);
   assign fence_hold      = FENCE_DRAIN & id_valid & dec_fence & store_in_flight;
   assign inject          = flush | (state != ST_RUN) | stall | fence_hold;
   assign ebreak_enter    = HALT_ON_EBREAK & id_valid & dec_ebreak & ~stall & ~flush;
   assign ebreak_killed   = flush & idex.valid & idex.is_ebreak;
   assign ebreak_retired  = memwb.valid & memwb.is_ebreak;
   assign fence_busy      = fence_hold & ~flush;

   // PC / IF-ID enable: HALTED freezes everything, then flush, then the holds
   always_comb begin
      advance = 1'b1;
      if (state == ST_HALTED)
         advance = 1'b0;
      else if (flush)
         advance = 1'b1;
      else if ((state == ST_DRAIN) | stall | fence_hold)
         advance = 1'b0;
   end

   assign pc_write   = advance;
   assign ifid_write = advance;

   // Stage registers: MEM/WB always shifts, EX/MEM and ID/EX take bubbles on kill/hold
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: these are a handful of control flops, not a memory array, so every one of them is reset to a bubble.
      if (!rst) begin
         idex  <= '0;
         exmem <= '0;
         memwb <= '0;
      end else begin
         // NOTE: non-blocking assignments let each stage read the previous stage's pre-edge value.
         memwb <= '{valid: exmem.valid, is_ebreak: exmem.is_ebreak, wb: exmem.wb};
         if (flush)
            exmem <= '0;
         else
            exmem <= '{valid: idex.valid, is_ebreak: idex.is_ebreak, mem: idex.mem, wb: idex.wb};
         if (inject)
            idex <= '0;
         else
            idex <= '{valid: id_valid, is_ebreak: HALT_ON_EBREAK & dec_ebreak,
                      ex: dec.ex, mem: dec.mem, wb: dec.wb};
      end
   end

   // Halt FSM with registered halted flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_RUN;
         halted <= 1'b0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (ebreak_enter) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (ebreak_killed) begin
                  state <= ST_RUN;
               end else if (ebreak_retired) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= ST_RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

   assign ex_ALUOp         = idex.ex.alu_op;
   assign ex_ALUSrc        = idex.ex.alu_src;
   assign mem_Branch       = exmem.mem.branch;
   assign mem_MemRead      = exmem.mem.mem_read;
   assign mem_MemWrite     = exmem.mem.mem_write;
   assign wb_MemtoReg      = memwb.wb.mem_to_reg;
   assign wb_RegWrite      = memwb.wb.reg_write;
   assign wb_rfWriteSelect = memwb.wb.rf_sel;
   assign idex_valid       = idex.valid;
   assign exmem_valid      = exmem.valid;
   assign memwb_valid      = memwb.valid;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: a slot-level pipeline model is
// compared against every output each cycle, plus directed literal checks.
module tb_pipe_control_unit;

   localparam logic [4:0] LOAD = 5'h00, FENCE = 5'h03, OPI = 5'h04, AUIPC = 5'h05,
                          STORE = 5'h08, OPR = 5'h0C, LUI = 5'h0D, BRANCH = 5'h18,
                          JALR = 5'h19, JAL = 5'h1B, SYSTEM = 5'h1C, UNKNOWN = 5'h1F;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_opcode = FENCE;
   logic       id_inst20 = 1'b0;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       resume = 1'b0;

   logic       pc_write, ifid_write, ex_ALUSrc, mem_Branch, mem_MemRead, mem_MemWrite;
   logic       wb_MemtoReg, wb_RegWrite, idex_valid, exmem_valid, memwb_valid;
   logic       fence_busy, halted;
   logic [1:0] ex_ALUOp, wb_rfWriteSelect;

   int n_checks = 0;
   int n_errors = 0;

   pipe_control_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_inst20(id_inst20), .stall(stall), .flush(flush), .resume(resume),
      .pc_write(pc_write), .ifid_write(ifid_write), .ex_ALUOp(ex_ALUOp),
      .ex_ALUSrc(ex_ALUSrc), .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead),
      .mem_MemWrite(mem_MemWrite), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
      .wb_rfWriteSelect(wb_rfWriteSelect), .idex_valid(idex_valid),
      .exmem_valid(exmem_valid), .memwb_valid(memwb_valid),
      .fence_busy(fence_busy), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A slot is an instruction occupying a stage: live=0 means an injected bubble.
   typedef struct packed {
      logic       live;
      logic       valid;
      logic [4:0] opc;
      logic       i20;
   } slot_t;

   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

   slot_t m_idex = '0, m_exmem = '0, m_memwb = '0;
   int    m_mode = M_RUN;

   // {ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, rfSel[1:0]}
   function automatic logic [9:0] table_bits(input logic [4:0] opc);
      case (opc)
         JALR:    return 10'b00_1_1_0_0_0_1_11;
         BRANCH:  return 10'b01_0_1_0_0_0_0_00;
         LOAD:    return 10'b00_1_0_1_0_1_1_00;
         STORE:   return 10'b00_1_0_0_1_0_0_00;
         OPI:     return 10'b10_1_0_0_0_0_1_00;
         OPR:     return 10'b10_0_0_0_0_0_1_00;
         JAL:     return 10'b00_0_1_0_0_0_1_11;
         AUIPC:   return 10'b11_0_0_0_0_0_1_10;
         LUI:     return 10'b11_0_0_0_0_0_1_01;
         SYSTEM:  return 10'b10_1_0_0_0_0_0_00;
         FENCE:   return 10'b00_0_0_0_0_0_0_00;
         default: return 10'b11_0_0_0_0_0_0_00;
      endcase
   endfunction

   function automatic logic [9:0] slot_bits(input slot_t s);
      return s.live ? table_bits(s.opc) : 10'b0;
   endfunction

   function automatic bit is_store(input slot_t s);
      return s.valid && s.opc == STORE;
   endfunction

   function automatic bit is_brk(input slot_t s);
      return s.valid && s.opc == SYSTEM && s.i20;
   endfunction

   function automatic bit m_fence_hold();
      return id_valid && id_opcode == FENCE && (is_store(m_idex) || is_store(m_exmem));
   endfunction

   function automatic bit m_pc_write();
      if (m_mode == M_HALT) return 1'b0;
      if (flush) return 1'b1;
      if (m_mode == M_DRAIN || stall || m_fence_hold()) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode  <= M_RUN;
         m_idex  <= '0;
         m_exmem <= '0;
         m_memwb <= '0;
      end else begin
         m_memwb <= m_exmem;
         m_exmem <= flush ? '0 : m_idex;
         if (flush || m_mode != M_RUN || stall || m_fence_hold())
            m_idex <= '0;
         else
            m_idex <= '{live: 1'b1, valid: id_valid, opc: id_opcode, i20: id_inst20};
         case (m_mode)
            M_RUN:   if (id_valid && id_opcode == SYSTEM && id_inst20 && !stall && !flush) m_mode <= M_DRAIN;
            M_DRAIN: if (flush && is_brk(m_idex)) m_mode <= M_RUN;
                     else if (is_brk(m_memwb)) m_mode <= M_HALT;
            default: if (resume) m_mode <= M_RUN;
         endcase
      end
   end

   // Every-cycle comparison, mid-way between the driving negedge and the next posedge
   initial begin
      forever begin
         @(negedge clk);
         #3;
         check("m_pc_write",    pc_write,         m_pc_write());
         check("m_ifid_write",  ifid_write,       m_pc_write());
         check("m_ex_ALUOp",    ex_ALUOp,         slot_bits(m_idex)[9:8]);
         check("m_ex_ALUSrc",   ex_ALUSrc,        slot_bits(m_idex)[7]);
         check("m_mem_Branch",  mem_Branch,       slot_bits(m_exmem)[6]);
         check("m_mem_MemRead", mem_MemRead,      slot_bits(m_exmem)[5]);
         check("m_mem_MemWrite",mem_MemWrite,     slot_bits(m_exmem)[4]);
         check("m_wb_MemtoReg", wb_MemtoReg,      slot_bits(m_memwb)[3]);
         check("m_wb_RegWrite", wb_RegWrite,      slot_bits(m_memwb)[2]);
         check("m_wb_rfSel",    wb_rfWriteSelect, slot_bits(m_memwb)[1:0]);
         check("m_idex_valid",  idex_valid,       m_idex.valid);
         check("m_exmem_valid", exmem_valid,      m_exmem.valid);
         check("m_memwb_valid", memwb_valid,      m_memwb.valid);
         check("m_fence_busy",  fence_busy,       m_fence_hold() && !flush);
         check("m_halted",      halted,           m_mode == M_HALT);
      end
   end

   // One cycle of stimulus; returns just before the next posedge so literal checks see this cycle
   task automatic cyc(input logic v, input logic [4:0] opc, input logic i20 = 1'b0,
                      input logic st = 1'b0, input logic fl = 1'b0, input logic rs = 1'b0);
      @(negedge clk);
      id_valid  = v;
      id_opcode = opc;
      id_inst20 = i20;
      stall     = st;
      flush     = fl;
      resume    = rs;
      #4;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, FENCE);
   endtask

   initial begin
      logic [4:0] extra [0:7];
      extra = '{JALR, JAL, AUIPC, LUI, OPR, UNKNOWN, SYSTEM, FENCE};

      #1 rst = 1'b0;
      idle(2);
      check("rst_pc_write",   pc_write,    1);
      check("rst_ifid_write", ifid_write,  1);
      check("rst_halted",     halted,      0);
      check("rst_fence_busy", fence_busy,  0);
      check("rst_valids",     {idex_valid, exmem_valid, memwb_valid}, 0);
      rst = 1'b1;

      // Hazard-free ADDI, SW, LW, BEQ
      cyc(1, OPI);
      cyc(1, STORE);
      check("s1_ex_aluop_addi", ex_ALUOp, 2);
      check("s1_ex_src_addi",   ex_ALUSrc, 1);
      cyc(1, LOAD);
      check("s1_ex_aluop_sw",   ex_ALUOp, 0);
      cyc(1, BRANCH);
      check("s1_wb_rw_addi",    wb_RegWrite, 1);
      check("s1_wb_m2r_addi",   wb_MemtoReg, 0);
      check("s1_mem_mw_sw",     mem_MemWrite, 1);
      check("s1_ex_aluop_lw",   ex_ALUOp, 0);
      check("s1_pc_write",      pc_write, 1);
      // decode coverage stream, includes unknown opcode and ECALL
      for (int i = 0; i < 8; i++) begin
         cyc(1, extra[i]);
         case (i)
            0: begin check("s1_wb_rw_sw", wb_RegWrite, 0); check("s1_mem_mr_lw", mem_MemRead, 1); end
            1: begin check("s1_wb_rw_lw", wb_RegWrite, 1); check("s1_wb_m2r_lw", wb_MemtoReg, 1);
                     check("s1_mem_br_beq", mem_Branch, 1); end
            2: begin check("s1_wb_rw_beq", wb_RegWrite, 0); check("s1_wb_m2r_beq", wb_MemtoReg, 0); end
            7: begin check("ecall_pc_write", pc_write, 1); check("ecall_halted", halted, 0); end
            default: ;
         endcase
      end
      idle(2);
      check("ecall_wb_rw", wb_RegWrite, 0);
      cyc(0, OPI);            // id_valid=0 still decodes but carries valid=0
      idle(3);

      // Load-use stall
      cyc(1, LOAD, 0, 1);
      check("stall_pc_write",   pc_write, 0);
      check("stall_ifid_write", ifid_write, 0);
      cyc(1, LOAD);
      check("stall_bubble",     idex_valid, 0);
      check("stall_release_pc", pc_write, 1);
      idle(1);
      check("stall_lw_enters",  idex_valid, 1);
      check("stall_lw_src",     ex_ALUSrc, 1);
      idle(3);

      // FENCE behind a store
      cyc(1, STORE);
      cyc(1, FENCE);
      check("fence_busy_1", fence_busy, 1);
      check("fence_pc_1",   pc_write, 0);
      cyc(1, FENCE);
      check("fence_busy_2", fence_busy, 1);
      cyc(1, FENCE);
      check("fence_busy_3", fence_busy, 0);
      check("fence_pc_3",   pc_write, 1);
      idle(1);
      check("fence_enters", idex_valid, 1);
      idle(3);

      // EBREAK drain, halt, resume
      cyc(1, SYSTEM, 1);
      check("brk_id_pc", pc_write, 1);
      idle(1);
      check("brk_drain1_pc", pc_write, 0);
      idle(1);
      check("brk_drain2_pc", pc_write, 0);
      idle(1);
      check("brk_drain3_pc", pc_write, 0);
      check("brk_in_memwb",  memwb_valid, 1);
      check("brk_not_yet",   halted, 0);
      idle(1);
      check("brk_halted",    halted, 1);
      check("brk_halt_pc",   pc_write, 0);
      cyc(0, FENCE, 0, 0, 1, 0);
      check("brk_halt_flush_pc", pc_write, 0);
      cyc(0, FENCE, 0, 0, 0, 1);
      check("brk_resume_cycle", halted, 1);
      idle(1);
      check("brk_resumed",   halted, 0);
      check("brk_resumed_pc",pc_write, 1);
      idle(2);

      // EBREAK killed by flush while in ID/EX
      cyc(1, SYSTEM, 1);
      cyc(0, FENCE, 0, 0, 1);
      check("kill_flush_pc", pc_write, 1);
      idle(1);
      check("kill_exmem_bubble", exmem_valid, 0);
      check("kill_run_pc",       pc_write, 1);
      idle(4);
      check("kill_never_halts",  halted, 0);

      // Stall and flush together
      cyc(1, OPI);
      cyc(1, LOAD, 0, 1, 1);
      check("sf_pc_write",   pc_write, 1);
      check("sf_ifid_write", ifid_write, 1);
      idle(1);
      check("sf_idex_bubble",  idex_valid, 0);
      check("sf_exmem_bubble", exmem_valid, 0);
      idle(3);

      // Asynchronous reset while HALTED
      cyc(1, SYSTEM, 1);
      idle(4);
      check("arst_pre_halted", halted, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_halted", halted, 0);
      check("arst_valids", {idex_valid, exmem_valid, memwb_valid}, 0);
      check("arst_pc",     pc_write, 1);
      idle(1);
      rst = 1'b1;
      idle(2);
      check("arst_run_pc", pc_write, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined successor to the team's single-cycle control decoder.
- Decodes the RV32I opcode in ID and carries the control bundles through the ID/EX, EX/MEM and MEM/WB registers.
- Owns bubble insertion for stall, flush, FENCE drain and EBREAK halt.
- Drives PC and IF/ID write enables; the hazard and branch units feed it `stall` and `flush`.

Parameters:
- OPC_W, 5: opcode field width (inst[6:2]).
- ALUOP_W, 2: ALUOp width.
- RFSEL_W, 2: rfWriteSelect width.
- FENCE_DRAIN, 1: 1 = FENCE holds in ID until no store is in flight; 0 = FENCE is a NOP.
- HALT_ON_EBREAK, 1: 1 = EBREAK drains then halts; 0 = EBREAK is a NOP.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- id_valid, in, 1: IF/ID holds a real instruction.
- id_opcode, in, OPC_W: instruction bits [6:2].
- id_inst20, in, 1: instruction bit 20 (ECALL=0, EBREAK=1).
- stall, in, 1: load-use stall request from the hazard unit.
- flush, in, 1: taken branch/jump resolved in EX/MEM; kills the IF/ID and ID/EX contents.
- resume, in, 1: single-cycle pulse that leaves HALTED.
- pc_write, out, 1: PC register enable.
- ifid_write, out, 1: IF/ID register enable.
- ex_ALUOp, ex_ALUSrc: ID/EX stage outputs, ALUOP_W and 1 bits.
- mem_Branch, mem_MemRead, mem_MemWrite: EX/MEM stage outputs, 1 bit each.
- wb_MemtoReg, wb_RegWrite, wb_rfWriteSelect: MEM/WB stage outputs, 1, 1 and RFSEL_W bits.
- idex_valid, exmem_valid, memwb_valid: out, 1 bit each; stage holds a live instruction.
- fence_busy, out, 1: FENCE is holding in ID.
- halted, out, 1: FSM is in HALTED.

Behaviour:
- Decode (combinational) uses the team's standard table:
  - JALR: ALUOp ADD, Br 1, Src 1, RegWrite 1, Sel 3.
  - BRANCH: SUB, Br 1.
  - LOAD: ADD, MemRead 1, MemtoReg 1, Src 1, RegWrite 1.
  - STORE: ADD, MemWrite 1, Src 1.
  - ARITH_I: FUNC, Src 1, RegWrite 1.
  - ARITH_R: FUNC, RegWrite 1.
  - JAL: ADD, Br 1, RegWrite 1, Sel 3.
  - AUIPC: ALUOp 3, RegWrite 1, Sel 2.
  - LUI: ALUOp 3, RegWrite 1, Sel 1.
  - SYSTEM: FUNC, Src 1.
  - FENCE: ADD, all others 0.
  - Unknown opcode: ALUOp 3, all others 0.
- Bubble: all control bits 0, ALUOp 0, valid 0.
- Reset (rst=0, async):
  - FSM = RUN; all stage registers are bubbles; all valid bits 0.
  - Outputs: pc_write=1, ifid_write=1, fence_busy=0, halted=0.
- Per rising edge:
  - MEM/WB <= EX/MEM, unconditionally.
  - EX/MEM <= bubble if flush, else ID/EX.
  - ID/EX <= bubble if inject, else decode with valid=id_valid.
- inject = flush | state!=RUN | stall | fence_hold.
- fence_hold = FENCE_DRAIN & id_valid & (opcode==FENCE) & ((idex_valid & idex MemWrite) | (exmem_valid & exmem MemWrite)).
- fence_busy = fence_hold & ~flush.
- Priority (highest first): flush > FSM state > stall > fence_hold.
- pc_write/ifid_write:
  - HALTED: 0 in all cases, including when flush is asserted.
  - Otherwise 1 if flush.
  - Otherwise 0 in DRAIN, or when stall or fence_hold is asserted.
  - Otherwise 1.
- FSM (RUN, DRAIN, HALTED); an is_ebreak flag travels with each stage.
  - RUN -> DRAIN: HALT_ON_EBREAK & id_valid & opcode==SYSTEM & id_inst20 & ~stall & ~flush. The EBREAK enters ID/EX on that edge.
  - DRAIN -> RUN: flush asserted while the EBREAK is in ID/EX; the EBREAK is killed.
  - DRAIN -> HALTED: memwb_valid & memwb is_ebreak.
  - HALTED -> RUN: resume; pc_write=1 in the next cycle.
  - resume is ignored outside HALTED.
- ECALL (inst20=0) flows through as a NOP; RegWrite=0 and no PC hold.
- Stall and flush in the same cycle: flush wins and pc_write=1.
- Reset mid-DRAIN or mid-HALTED returns to RUN immediately, with all bubbles.

Decomposition:
- Shared defines header: opcode constants (5-bit), ALUOP_ADD/SUB/FUNC, rfWriteSelect codes, FSM state encodings.
- Sub-module `ctrl_decode`: the combinational opcode-to-bundle table. It reuses the single-cycle table and adds is_ebreak and is_fence outputs.
- The top module holds the stage registers, the FSM and the hold logic.

Test Plan:
- Reset then stream of ADDI, SW, LW, BEQ (no hazards). Required: each bundle appears on ex_ one cycle after ID, then on mem_ and wb_ one cycle apart each. The wb_ sequence is RegWrite 1,0,1,0; wb_MemtoReg is 1 only for the LW. pc_write stays 1.
- LW in ID with stall=1 for one cycle. Required: pc_write=0 and ifid_write=0 that cycle; ID/EX receives a bubble (idex_valid=0); the LW enters ID/EX on the next edge.
- SW in ID/EX with FENCE in ID. Required: fence_busy=1 for 2 cycles (SW in ID/EX, then EX/MEM); the FENCE advances in the 3rd cycle.
- EBREAK in ID. Required: DRAIN for 3 cycles with pc_write=0; halted=1 when the EBREAK reaches MEM/WB; resume pulse gives pc_write=1 and halted=0 in the next cycle.
- EBREAK in ID/EX (DRAIN) with flush=1. Required: EX/MEM receives a bubble, state returns to RUN, pc_write=1; halted never asserts.
- stall=1 and flush=1 simultaneously. Required: pc_write=1; ID/EX and EX/MEM both receive bubbles. Separately, assert rst=0 during HALTED: halted=0 and all valid bits 0 immediately, without waiting for a clock edge.
